// File: rtl/pipe_halt_buffer.sv
// Skid/halt buffer behind an enabled-register pipeline. It asks upstream to halt
// early enough to absorb the SLACK stages that are still in flight, then drains in order.
module pipe_halt_buffer #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   parameter int SLACK = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             halt_o,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             halt_i,
   output logic             overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_HALT  = CNT_W'(DEPTH - SLACK);

   generate
      if (SLACK >= DEPTH || DEPTH < 2 || SLACK < 0) begin : g_bad_params
         $error("pipe_halt_buffer: need DEPTH >= 2 and 0 <= SLACK < DEPTH");
      end
   endgenerate

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_halt;
   logic             r_overflow;

   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_wr_en;
   logic             w_drop;
   logic [CNT_W-1:0] w_count_next;
   logic [PTR_W-1:0] w_wr_ptr_inc;
   logic [PTR_W-1:0] w_rd_ptr_inc;

   assign out_valid = (r_count != '0);
   assign out_data  = r_mem[r_rd_ptr];
   assign halt_o    = r_halt;
   assign overflow  = r_overflow;

   assign w_push = in_valid;
   assign w_pop  = out_valid & ~halt_i;
   assign w_full = (r_count == CNT_FULL);
   // A pop frees the slot the simultaneous push lands in, so a full buffer can still write.
   assign w_wr_en = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

   assign w_wr_ptr_inc = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_ptr_inc = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

   always_comb begin
      w_count_next = r_count;
      if (w_wr_en && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (w_pop && !w_wr_en) begin
         w_count_next = r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_halt     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= w_wr_ptr_inc;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
         r_count <= w_count_next;
         r_halt  <= (w_count_next >= CNT_HALT);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Storage has no reset; only the pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      if (w_wr_en && !reset) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

endmodule

// File: tb/tb_pipe_halt_buffer.sv
// Directed bench for pipe_halt_buffer (WIDTH=8, DEPTH=4, SLACK=2): a vector table
// for reset/pass-through/threshold/overflow plus sequences for full-wrap and mid-run reset.
module tb_pipe_halt_buffer;

   logic       clk;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       halt_o;
   logic [7:0] out_data;
   logic       out_valid;
   logic       halt_i;
   logic       overflow;

   int n_checks;
   int n_errors;

   pipe_halt_buffer #(.WIDTH(8), .DEPTH(4), .SLACK(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .halt_o    (halt_o),
      .out_data  (out_data),
      .out_valid (out_valid),
      .halt_i    (halt_i),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       iv;
      logic [7:0] d;
      logic       hi;
      logic       chk;
      logic       ev;
      logic [7:0] ed;
      logic       eh;
      logic       eo;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t mk(input logic rst, input logic iv, input logic [7:0] d,
                               input logic hi, input logic chk, input logic ev,
                               input logic [7:0] ed, input logic eh, input logic eo);
      vec_t v;
      v.rst = rst; v.iv = iv; v.d = d; v.hi = hi; v.chk = chk;
      v.ev = ev; v.ed = ed; v.eh = eh; v.eo = eo;
      return v;
   endfunction

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic rst, input logic iv, input logic [7:0] d, input logic hi);
      @(negedge clk);
      reset    = rst;
      in_valid = iv;
      in_data  = d;
      halt_i   = hi;
      #1;
   endtask

   task automatic check(input string nm, input logic ev, input logic [7:0] ed,
                        input logic eh, input logic eo);
      n_checks++;
      if (out_valid !== ev) begin
         n_errors++;
         $display("FAIL %s out_valid got %b want %b", nm, out_valid, ev);
      end
      n_checks++;
      if (ev && out_data !== ed) begin
         n_errors++;
         $display("FAIL %s out_data got %h want %h", nm, out_data, ed);
      end
      n_checks++;
      if (halt_o !== eh) begin
         n_errors++;
         $display("FAIL %s halt_o got %b want %b", nm, halt_o, eh);
      end
      n_checks++;
      if (overflow !== eo) begin
         n_errors++;
         $display("FAIL %s overflow got %b want %b", nm, overflow, eo);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      halt_i   = 1'b0;

      // rst iv d hi | chk ev ed eh eo  (expected = outputs seen during that row)
      tbl[0]  = mk(1, 1, 8'hEE, 0, 0, 0, 8'h00, 0, 0);
      tbl[1]  = mk(1, 1, 8'hEE, 0, 1, 0, 8'h00, 0, 0);
      tbl[2]  = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
      tbl[3]  = mk(0, 1, 8'h11, 0, 1, 0, 8'h00, 0, 0);
      tbl[4]  = mk(0, 0, 8'h00, 0, 1, 1, 8'h11, 0, 0);
      tbl[5]  = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
      tbl[6]  = mk(0, 1, 8'hA0, 1, 1, 0, 8'h00, 0, 0);
      tbl[7]  = mk(0, 1, 8'hA1, 1, 1, 1, 8'hA0, 0, 0);
      tbl[8]  = mk(0, 0, 8'h00, 1, 1, 1, 8'hA0, 1, 0);
      tbl[9]  = mk(0, 0, 8'h00, 0, 1, 1, 8'hA0, 1, 0);
      tbl[10] = mk(0, 0, 8'h00, 1, 1, 1, 8'hA1, 0, 0);
      tbl[11] = mk(0, 0, 8'h00, 0, 1, 1, 8'hA1, 0, 0);
      tbl[12] = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
      tbl[13] = mk(0, 1, 8'h01, 1, 1, 0, 8'h00, 0, 0);
      tbl[14] = mk(0, 1, 8'h02, 1, 1, 1, 8'h01, 0, 0);
      tbl[15] = mk(0, 1, 8'h03, 1, 1, 1, 8'h01, 1, 0);
      tbl[16] = mk(0, 1, 8'h04, 1, 1, 1, 8'h01, 1, 0);
      tbl[17] = mk(0, 1, 8'h05, 1, 1, 1, 8'h01, 1, 0);
      tbl[18] = mk(0, 0, 8'h00, 0, 1, 1, 8'h01, 1, 1);
      tbl[19] = mk(0, 0, 8'h00, 0, 1, 1, 8'h02, 1, 1);
      tbl[20] = mk(0, 0, 8'h00, 0, 1, 1, 8'h03, 1, 1);
      tbl[21] = mk(0, 0, 8'h00, 0, 1, 1, 8'h04, 0, 1);
      tbl[22] = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1);
      tbl[23] = mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1);
      tbl[24] = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);

      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].hi);
         if (tbl[i].chk) begin
            check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eh, tbl[i].eo);
         end
      end

      // Full buffer: fill under halt, then push and pop every cycle across wraps.
      drive(1, 0, 8'h00, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 8'h10 + 8'(i), 1);
      end
      for (int k = 0; k < 10; k++) begin
         drive(0, (k < 6), 8'h14 + 8'(k), 0);
         check($sformatf("wrap%0d", k), 1'b1, 8'h10 + 8'(k), (k <= 8), 1'b0);
      end
      drive(0, 0, 8'h00, 0);
      check("wrap_empty", 1'b0, 8'h00, 1'b0, 1'b0);

      // Reset in the middle of a run, with a push presented in the reset cycle.
      drive(1, 0, 8'h00, 0);
      drive(0, 1, 8'h31, 1);
      drive(0, 1, 8'h32, 1);
      drive(0, 1, 8'h33, 1);
      drive(1, 1, 8'h99, 0);
      check("midrst_pre", 1'b1, 8'h31, 1'b1, 1'b0);
      drive(0, 0, 8'h00, 0);
      check("midrst_post", 1'b0, 8'h00, 1'b0, 1'b0);
      drive(0, 1, 8'h7E, 0);
      check("midrst_push", 1'b0, 8'h00, 1'b0, 1'b0);
      drive(0, 0, 8'h00, 0);
      check("midrst_7e", 1'b1, 8'h7E, 1'b0, 1'b0);
      drive(0, 0, 8'h00, 0);
      check("midrst_alone", 1'b0, 8'h00, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
